// File: rtl/mux_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the round-robin 4:1 mux scheduler.
//   N_REQ   : number of requesters sharing the datapath
//   SEL_W   : width of the mux select / lane index
//   state_t : scheduler FSM states (IDLE between grants, GRANT while serving)
//   pick_t  : result of the rotating-priority search (found flag + lane index)
// -----------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

endpackage : mux_sched_pkg

// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
// 1-bit 4:1 multiplexer cell.
//   i_d0..i_d3 : data inputs
//   i_s1, i_s0 : select, {i_s1,i_s0} picks i_d<n>
//   o_y        : selected bit
// -----------------------------------------------------------------------------
module mux_4x1 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_d2,
    input  logic i_d3,
    input  logic i_s1,
    input  logic i_s0,
    output logic o_y
);

    assign o_y = i_s1 ? (i_s0 ? i_d3 : i_d2)
                      : (i_s0 ? i_d1 : i_d0);

endmodule : mux_4x1

// File: rtl/mux_4x1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_4x1_rr_sched
// Round-robin scheduler sharing one 4:1 multiplexed datapath between four
// requesters. Each grant is capped at MAX_HOLD accepted beats, and the FSM
// always passes through IDLE for one cycle between grants.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req       : per-lane request (level-sensitive)
//   data_in   : lane i at [i*DATA_W +: DATA_W]
//   out_ready : downstream accepts a beat this cycle
//   gnt       : registered one-hot grant, zero while idle
//   sel       : registered mux select (index of granted / last granted lane)
//   out_valid : granted lane currently has a beat
//   out_data  : data_in lane [sel], driven at all times
//   busy      : high while in GRANT
// -----------------------------------------------------------------------------
module mux_4x1_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    busy
);

    localparam int                 HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;

    pick_t               w_pick;
    logic                w_busy;
    logic                w_sel_req;
    logic                w_beat;
    logic                w_release;

    // Rotating-priority search: first set request at ptr, ptr+1, ... (mod 4).
    // The loop runs from the farthest offset down so the nearest hit is the
    // last one written and therefore wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req_v,
                                      input logic [SEL_W-1:0] ptr_v);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        // NOTE: every variable gets a value before any conditional write, so
        // no path leaves it holding a previous value (which would be a latch).
        p   = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_v + SEL_W'(i);   // wraps mod 4 by width
            if (req_v[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_busy    = (r_state == ST_GRANT);
    assign w_sel_req = req[r_sel];
    assign w_beat    = w_busy & w_sel_req & out_ready;

    // Release when the owner drops its request, or when the beat that fills
    // the quota is accepted. Both at once is still a single release.
    assign w_release = w_busy & (~w_sel_req | (w_beat & (r_hold_cnt == HOLD_LAST)));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick.found) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= N_REQ'(1) << w_pick.idx;
                        r_sel      <= w_pick.idx;
                        r_hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        // sel keeps its value so out_data stays defined in IDLE
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= r_sel + SEL_W'(1);
                    end else if (w_beat) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // One 1-bit cell per data bit; cell b sees bit b of every lane.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit_mux
        mux_4x1 u_mux (
            .i_d0 (data_in[0*DATA_W + b]),
            .i_d1 (data_in[1*DATA_W + b]),
            .i_d2 (data_in[2*DATA_W + b]),
            .i_d3 (data_in[3*DATA_W + b]),
            .i_s1 (r_sel[1]),
            .i_s0 (r_sel[0]),
            .o_y  (out_data[b])
        );
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = w_busy;
    assign out_valid = w_busy & w_sel_req;

endmodule : mux_4x1_rr_sched

// File: tb/tb_mux_4x1_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1_rr_sched
// Self-checking bench for mux_4x1_rr_sched. A behavioural model tracks which
// lane owns the datapath, how many beats it has delivered and where the
// round-robin search starts; every cycle the DUT outputs are compared to it.
// Directed scenarios add explicit constant checks on top.
// -----------------------------------------------------------------------------
module tb_mux_4x1_rr_sched;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: owner lane (-1 = nobody), beats served, search start, select
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    always #5 clk = ~clk;

    mux_4x1_rr_sched #(
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare outputs with the model, then advance
    // the model across the coming rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                        input logic rdy);
        bit owner_req;
        @(negedge clk);
        rst       = r;
        req       = rq;
        data_in   = d;
        out_ready = rdy;
        #1;
        owner_req = (m_owner >= 0) && rq[m_owner];
        check("gnt",       {28'd0, gnt},     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("sel",       {30'd0, sel},     m_sel);
        check("busy",      {31'd0, busy},    (m_owner >= 0) ? 32'd1 : 32'd0);
        check("out_valid", {31'd0, out_valid}, owner_req ? 32'd1 : 32'd0);
        check("out_data",  {24'd0, out_data}, (d >> (8 * m_sel)) & 32'hFF);

        if (r) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int lane;
                lane = (m_ptr + i) % 4;
                if (rq[lane]) begin
                    m_owner = lane; m_sel = lane; m_beats = 0;
                    break;
                end
            end
        end else begin
            bit done;
            done = 1'b0;
            if (!owner_req) begin
                done = 1'b1;
            end else if (rdy) begin
                m_beats++;
                if (m_beats == MAX_HOLD) done = 1'b1;
            end
            if (done) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    endtask

    initial begin
        int          order [6];
        int          beats [6];
        int          g;
        logic        prev_busy;
        logic [3:0]  rq_r;

        // Initial reset edge so outputs are defined before checking starts.
        rst = 1'b1; req = 4'hF; data_in = '0; out_ready = 1'b0;
        @(posedge clk);

        // 1. reset held with all requests up
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF, 32'h0, 1'b1);
            check("rst_gnt",  {28'd0, gnt}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_oval", {31'd0, out_valid}, 32'd0);
        end

        // 2. single requester lane 2, quota then re-grant
        step(1'b0, 4'b0100, 32'h44A52211, 1'b1);
        step(1'b0, 4'b0100, 32'h44A52211, 1'b1);
        check("t2_gnt",  {28'd0, gnt}, 32'h4);
        check("t2_sel",  {30'd0, sel}, 32'd2);
        check("t2_data", {24'd0, out_data}, 32'hA5);
        check("t2_oval", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 32'h44A52211, 1'b1);
        step(1'b0, 4'b0100, 32'h44A52211, 1'b1);
        check("t2_gap", {28'd0, gnt}, 32'd0);
        step(1'b0, 4'b0100, 32'h44A52211, 1'b1);
        check("t2_regnt", {28'd0, gnt}, 32'h4);

        // 3. all lanes requesting: order 0,1,2,3,0 with MAX_HOLD beats each
        step(1'b1, 4'h0, 32'h0, 1'b1);
        g = -1; prev_busy = 1'b0;
        foreach (beats[k]) begin beats[k] = 0; order[k] = -1; end
        for (int c = 0; c < 40 && g < 5; c++) begin
            step(1'b0, 4'hF, $urandom, 1'b1);
            if (busy && !prev_busy) begin
                g++;
                if (g < 6) order[g] = int'(sel);
            end
            if (busy && out_valid && g >= 0 && g < 6) beats[g]++;
            prev_busy = busy;
        end
        check("t3_grants_seen", g, 5);
        for (int k = 0; k < 5; k++) check("t3_order", order[k], k % 4);
        for (int k = 0; k < 5; k++) check("t3_beats", beats[k], MAX_HOLD);

        // 4. lane 1 stalled by downstream, then drained
        step(1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b0, 4'b0010, 32'h0000C300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0010, 32'h0000C300, 1'b0);
            check("t4_stall_gnt",  {28'd0, gnt}, 32'h2);
            check("t4_stall_oval", {31'd0, out_valid}, 32'd1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, 32'h0000C300, 1'b1);
        step(1'b0, 4'b0010, 32'h0000C300, 1'b1);
        check("t4_release", {31'd0, busy}, 32'd0);

        // 5. lane 0 drops after 2 beats, lane 1 follows two cycles later
        step(1'b1, 4'h0, 32'h0, 1'b1);
        step(1'b0, 4'b0011, 32'h0, 1'b1);
        step(1'b0, 4'b0011, 32'h0, 1'b1);
        step(1'b0, 4'b0011, 32'h0, 1'b1);
        step(1'b0, 4'b0010, 32'h0, 1'b1);
        check("t5_drop_oval", {31'd0, out_valid}, 32'd0);
        step(1'b0, 4'b0010, 32'h0, 1'b1);
        step(1'b0, 4'b0010, 32'h0, 1'b1);
        check("t5_lane1", {28'd0, gnt}, 32'h2);

        // 6. reset during beat 2 of lane 3, then lane 0 wins from ptr=0
        step(1'b1, 4'h0, 32'h0, 1'b1);
        step(1'b0, 4'b1000, 32'h0, 1'b1);
        step(1'b0, 4'b1000, 32'h0, 1'b1);
        step(1'b1, 4'b1000, 32'h0, 1'b1);
        step(1'b0, 4'b1001, 32'h0, 1'b1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 4'b1001, 32'h0, 1'b1);
        check("t6_lane0", {28'd0, gnt}, 32'h1);

        // Randomized traffic: sticky requests, random back-pressure, rare resets
        rq_r = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rq_r[b] = ~rq_r[b];
            step(($urandom_range(0, 199) == 0), rq_r, $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_4x1_rr_sched
